// File: rtl/sevseg_scan_n.sv
// sevseg_scan_n -- N-digit time-multiplexed seven-segment display controller.
//
// Scans NUM_DIGITS hex digits onto one shared segment bus. Each digit gets a
// slot of REFRESH_DIV clocks. The first DEAD_CYCLES clocks of every slot are
// blanked to stop ghosting, and the rest of the slot drives that digit. The
// digit inputs are captured once per frame, so a change in the middle of a
// frame never tears the display. The sum of the captured digits is
// registered one clock after the frame starts.
//
// Optional feature: define SEVSEG_LZB_EN to enable leading-zero blanking.
// Digit 0 is never blanked, and slot timing and the sum are unaffected.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous reset, active low
//   digits      in   4*NUM_DIGITS; digit i = digits[4i+3:4i]
//   en          out  one-hot digit enables (polarity set by EN_ACTIVE_LOW)
//   seg         out  segments, seg[0]=a .. seg[6]=g (polarity set by SEG_ACTIVE_LOW)
//   sum         out  unsigned sum of the captured digits
//   frame_tick  out  one-clock pulse at each frame start
module sevseg_scan_n #(
  parameter int unsigned NUM_DIGITS     = 2,
  parameter int unsigned REFRESH_DIV    = 24000,
  parameter int unsigned DEAD_CYCLES    = 240,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          EN_ACTIVE_LOW  = 1'b1,
  localparam int unsigned SUM_W = $clog2(15*NUM_DIGITS+1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   en,
  output logic [6:0]              seg,
  output logic [SUM_W-1:0]        sum,
  output logic                    frame_tick
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] EN_OFF = EN_ACTIVE_LOW ? '1 : '0;

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           pre_q, pre_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic                    frame_start;
  logic [3:0]              dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lzb;
  logic [NUM_DIGITS-1:0]   en_d;
  logic [6:0]              seg_d;
  logic [SUM_W-1:0]        sum_d;
`ifdef SEVSEG_LZB_EN
  logic                    upper_zero;
  int unsigned             di;
`endif

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'b1000000;
      4'h1: p = 7'b1111001;
      4'h2: p = 7'b0100100;
      4'h3: p = 7'b0110000;
      4'h4: p = 7'b0011001;
      4'h5: p = 7'b0010010;
      4'h6: p = 7'b0000010;
      4'h7: p = 7'b1111000;
      4'h8: p = 7'b0000000;
      4'h9: p = 7'b0010000;
      4'hA: p = 7'b0001000;
      4'hB: p = 7'b0000011;
      4'hC: p = 7'b1000110;
      4'hD: p = 7'b0100001;
      4'hE: p = 7'b0000110;
      default: p = 7'b0001110;
    endcase
    return SEG_ACTIVE_LOW ? p : ~p;
  endfunction

  // pre_q/idx_q name the slot position that the next clock edge moves into.
  // Every output is therefore registered from that position. A frame starts
  // when the scan moves into position 0 of digit 0. That edge also loads the
  // snapshot, so the new digit value is decoded straight from snap_d.
  always_comb begin
    frame_start = (pre_q == '0) && (idx_q == '0);
    snap_d      = frame_start ? digits : snap_q;
    pre_d       = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    idx_d       = idx_q;
    if (pre_q == PRE_LAST) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. Each slot opens in BLANK unless DEAD_CYCLES is zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK:   if (int'(pre_q) >= int'(DEAD_CYCLES)) state_d = DRIVE;
      DRIVE:   if ((pre_q == '0) && (DEAD_CYCLES != 0)) state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  // Output decode for the position being entered.
  always_comb begin
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      dig[i] = snap_d[4*i +: 4];
    end
    lzb = '0;
`ifdef SEVSEG_LZB_EN
    upper_zero = 1'b1;
    di         = 0;
    for (int unsigned k = 0; k + 1 < NUM_DIGITS; k++) begin
      di         = NUM_DIGITS - 1 - k;
      upper_zero = upper_zero && (dig[di] == 4'h0);
      lzb[di]    = upper_zero;
    end
`endif
    en_d  = EN_OFF;
    seg_d = SEG_OFF;
    if ((state_d == DRIVE) && !lzb[idx_q]) begin
      en_d  = EN_OFF ^ (NUM_DIGITS'(1) << idx_q);
      seg_d = decode(dig[idx_q]);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      sum_d = sum_d + SUM_W'(snap_q[4*i +: 4]);
    end
  end

  // Counters, snapshot and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q      <= '0;
      idx_q      <= '0;
      snap_q     <= '0;
      en         <= EN_OFF;
      seg        <= SEG_OFF;
      sum        <= '0;
      frame_tick <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      en         <= en_d;
      seg        <= seg_d;
      sum        <= sum_d;
      frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_sevseg_scan_n.sv
module tb_sevseg_scan_n;
  localparam int N  = 2;
  localparam int R  = 8;
  localparam int D  = 2;
  localparam int FR = N * R;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  digits = 8'h00;
  logic [15:0] digits4 = 16'h0000;
  logic [1:0]  en;
  logic [6:0]  seg;
  logic [4:0]  sum;
  logic        frame_tick;
  logic [3:0]  en4;
  logic [6:0]  seg4;
  logic [5:0]  sum4;
  logic        ft4;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sevseg_scan_n #(.NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D),
                  .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)) u_dut (
    .clk(clk), .reset(reset), .digits(digits), .en(en), .seg(seg),
    .sum(sum), .frame_tick(frame_tick));

  sevseg_scan_n #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1),
                  .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)) u_dut4 (
    .clk(clk), .reset(reset), .digits(digits4), .en(en4), .seg(seg4),
    .sum(sum4), .frame_tick(ft4));

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model: m_e counts clock edges since reset release (-1 = not started).
  int         m_e;
  logic [7:0] m_snap, m_prev_snap;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_e         <= -1;
      m_snap      <= 8'h00;
      m_prev_snap <= 8'h00;
    end else begin
      m_e <= m_e + 1;
      if ((m_e + 1) % FR == 0) m_snap <= digits;
      m_prev_snap <= m_snap;
    end
  end

  function automatic bit lz_blank(int d, logic [7:0] s);
`ifdef SEVSEG_LZB_EN
    return (d > 0) && ((s >> (4*d)) == 8'h00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [1:0] exp_en(int e, logic [7:0] s);
    int pos, d;
    if (e < 0) return 2'b11;
    pos = e % R;
    d = (e / R) % N;
    if (pos < D || lz_blank(d, s)) return 2'b11;
    return ~(2'b01 << d);
  endfunction

  function automatic logic [6:0] exp_seg(int e, logic [7:0] s);
    int pos, d;
    if (e < 0) return 7'h7F;
    pos = e % R;
    d = (e / R) % N;
    if (pos < D || lz_blank(d, s)) return 7'h7F;
    return seg_tab[(s >> (4*d)) & 8'h0F];
  endfunction

  function automatic logic exp_tick(int e);
    return (e >= 0) && (e % FR == 0);
  endfunction

  task automatic wait_pos(input int modv, input int ph);
    int k;
    k = 0;
    while (!(m_e >= 0 && m_e % modv == ph) && k < 200) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k >= 200) begin
      bad++;
      $display("FAIL wait_pos: timed out after %0d cycles waiting for phase %0d", k, ph);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    digits = 8'h3A;
    digits4 = 16'hFFFF;
    repeat (3) @(negedge clk);
    total++; if (en !== 2'b11) begin bad++; $display("FAIL reset_en: got %b want 11", en); end
    total++; if (seg !== 7'h7F) begin bad++; $display("FAIL reset_seg: got %b want 1111111", seg); end
    total++; if (sum !== 5'd0) begin bad++; $display("FAIL reset_sum: got %0d want 0", sum); end
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
    total++; if (en4 !== 4'hF) begin bad++; $display("FAIL reset_en4: got %b want 1111", en4); end
  endtask

  task automatic test_scan;
    reset = 1'b1;
    for (int c = 0; c < 2*FR; c++) begin
      @(negedge clk);
      total++;
      if (en !== exp_en(m_e, m_snap)) begin bad++; $display("FAIL scan_en: e=%0d got %b want %b", m_e, en, exp_en(m_e, m_snap)); end
      total++;
      if (seg !== exp_seg(m_e, m_snap)) begin bad++; $display("FAIL scan_seg: e=%0d got %b want %b", m_e, seg, exp_seg(m_e, m_snap)); end
      total++;
      if (frame_tick !== exp_tick(m_e)) begin bad++; $display("FAIL scan_tick: e=%0d got %b want %b", m_e, frame_tick, exp_tick(m_e)); end
      if (m_e == 1) begin
        total++;
        if (sum !== 5'd13) begin bad++; $display("FAIL scan_sum13: got %0d want 13", sum); end
      end
      if (m_e == D) begin
        total++;
        if (seg !== 7'b0001000 || en !== 2'b10) begin bad++; $display("FAIL scan_digit0: en=%b seg=%b want 10/0001000", en, seg); end
      end
    end
  endtask

  task automatic test_mid_change;
    wait_pos(FR, 5);
    digits = 8'h12;
    wait_pos(FR, R + D);
    total++;
    if (seg !== 7'b0110000 || sum !== 5'd13) begin bad++; $display("FAIL mid_hold: seg=%b sum=%0d want 0110000/13", seg, sum); end
    wait_pos(FR, 1);
    total++;
    if (sum !== 5'd3) begin bad++; $display("FAIL mid_sum3: got %0d want 3", sum); end
    wait_pos(FR, 3);
    total++;
    if (seg !== 7'b0100100 || en !== 2'b10) begin bad++; $display("FAIL mid_seg2: en=%b seg=%b want 10/0100100", en, seg); end
  endtask

  task automatic test_random;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      total++;
      if (en !== exp_en(m_e, m_snap)) begin bad++; $display("FAIL rnd_en: e=%0d got %b want %b", m_e, en, exp_en(m_e, m_snap)); end
      total++;
      if (seg !== exp_seg(m_e, m_snap)) begin bad++; $display("FAIL rnd_seg: e=%0d got %b want %b", m_e, seg, exp_seg(m_e, m_snap)); end
      total++;
      if (frame_tick !== exp_tick(m_e)) begin bad++; $display("FAIL rnd_tick: e=%0d got %b", m_e, frame_tick); end
      total++;
      if (sum !== 5'(m_prev_snap[3:0] + m_prev_snap[7:4])) begin bad++; $display("FAIL rnd_sum: e=%0d got %0d want %0d", m_e, sum, m_prev_snap[3:0] + m_prev_snap[7:4]); end
      total++;
      if (en === 2'b00 || ($countones(~en4) > 1)) begin bad++; $display("FAIL rnd_onehot: en=%b en4=%b", en, en4); end
      if ($urandom_range(4) == 0) digits = 8'($urandom);
    end
  endtask

  task automatic test_ff;
    int e4;
    digits = 8'hFF;
    repeat (2*FR + 2) @(negedge clk);
    total++; if (sum !== 5'd30) begin bad++; $display("FAIL ff_sum: got %0d want 30", sum); end
    total++; if (sum4 !== 6'd60) begin bad++; $display("FAIL ff_sum4: got %0d want 60", sum4); end
    digits4 = 16'($urandom);
    e4 = 0;
    for (int i = 0; i < 4; i++) e4 += (digits4 >> (4*i)) & 16'hF;
    repeat (40) @(negedge clk);
    total++; if (sum4 !== 6'(e4)) begin bad++; $display("FAIL rnd_sum4: got %0d want %0d", sum4, e4); end
  endtask

  task automatic test_async_reset;
    digits = 8'h3A;
    wait_pos(R, 4);
    #2 reset = 1'b0;
    #1;
    total++;
    if (en !== 2'b11 || seg !== 7'h7F || sum !== 5'd0 || frame_tick !== 1'b0) begin
      bad++; $display("FAIL async_reset: en=%b seg=%b sum=%0d tick=%b", en, seg, sum, frame_tick);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < R + D + 1; c++) begin
      @(negedge clk);
      total++;
      if (en !== exp_en(m_e, m_snap) || seg !== exp_seg(m_e, m_snap)) begin
        bad++; $display("FAIL restart: e=%0d en=%b seg=%b want %b/%b", m_e, en, seg, exp_en(m_e, m_snap), exp_seg(m_e, m_snap));
      end
      if (m_e == 0) begin
        total++;
        if (en !== 2'b11 || frame_tick !== 1'b1) begin bad++; $display("FAIL restart_blank: en=%b tick=%b want 11/1", en, frame_tick); end
      end
    end
  endtask

  task automatic test_lzb;
    for (int p = 0; p < 2; p++) begin
      digits = (p == 0) ? 8'h05 : 8'h00;
      wait_pos(FR, FR - 1);
      for (int c = 0; c < FR; c++) begin
        @(negedge clk);
        total++;
        if (en !== exp_en(m_e, m_snap) || seg !== exp_seg(m_e, m_snap)) begin
          bad++; $display("FAIL lzb: e=%0d en=%b seg=%b want %b/%b", m_e, en, seg, exp_en(m_e, m_snap), exp_seg(m_e, m_snap));
        end
        if (m_e % FR == D) begin
          total++;
          if (seg !== ((p == 0) ? 7'b0010010 : 7'b1000000)) begin bad++; $display("FAIL lzb_d0: got %b", seg); end
        end
`ifdef SEVSEG_LZB_EN
        if (m_e % FR >= R) begin
          total++;
          if (en !== 2'b11) begin bad++; $display("FAIL lzb_d1: e=%0d en=%b want 11", m_e, en); end
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_mid_change();
    test_random();
    test_ff();
    test_async_reset();
    test_lzb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
